// File: rtl/llc_trace_frontend_pkg.sv
// Shared types and widths for the LLC trace front-end: command codes,
// address field widths and the buffered command layout.
package llc_trace_frontend_pkg;

    localparam int DEF_ADDR_BITS = 32;
    localparam int DEF_SETS      = 2 ** 14;
    localparam int DEF_LINE_SIZE = 64;

    localparam int INDEX_W  = $clog2(DEF_SETS);
    localparam int OFFSET_W = $clog2(DEF_LINE_SIZE);
    localparam int TAG_W    = DEF_ADDR_BITS - INDEX_W - OFFSET_W;

    typedef enum logic [3:0] {
        CMD_RD_D     = 4'd0,
        CMD_WR_D     = 4'd1,
        CMD_RD_I     = 4'd2,
        CMD_SNP_INV  = 4'd3,
        CMD_SNP_RD   = 4'd4,
        CMD_SNP_WR   = 4'd5,
        CMD_SNP_RWIM = 4'd6,
        CMD_CLEAR    = 4'd8,
        CMD_PRINT    = 4'd9
    } cmd_e;

    // One buffered trace command, as held in the input FIFO.
    typedef struct packed {
        logic [3:0]               cmd;
        logic [DEF_ADDR_BITS-1:0] addr;
    } trace_cmd_t;

    function automatic logic cmd_legal(input logic [3:0] c);
        return (c <= 4'd6) || (c == 4'd8) || (c == 4'd9);
    endfunction

endpackage

// File: rtl/llc_trace_frontend_fifo.sv
// Small synchronous FIFO with registered head; push is ignored when full and
// pop is ignored when empty. DEPTH must be a power of two.
module llc_sync_fifo
    import llc_trace_frontend_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: contents are only observed once count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/llc_trace_frontend.sv
// LLC trace front-end: buffers trace commands, decodes tag/index/offset,
// drops illegal codes and expands clear into a sweep over every set.
module llc_trace_frontend
    import llc_trace_frontend_pkg::*;
#(
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int SETS       = DEF_SETS,
    parameter int LINE_SIZE  = DEF_LINE_SIZE,
    parameter int FIFO_DEPTH = 4,
    localparam int IW = $clog2(SETS),
    localparam int OW = $clog2(LINE_SIZE),
    localparam int TW = ADDR_BITS - IW - OW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_cmd,
    input  logic [ADDR_BITS-1:0] in_addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_cmd,
    output logic [TW-1:0]        out_tag,
    output logic [IW-1:0]        out_index,
    output logic [OW-1:0]        out_offset,
    output logic                 out_last,
    output logic [15:0]          err_count,
    output logic                 busy
);

    localparam logic [0:0] ST_PASS  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    // Both handshakes: a transfer happens on a rising edge where valid && ready;
    // a presented output holds all its fields until it is accepted.
    logic [0:0]                 state;
    logic [IW-1:0]              sweep_idx;
    trace_cmd_t                 push_entry;
    logic [$bits(trace_cmd_t)-1:0] head_raw;
    trace_cmd_t                 head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       pop;
    logic                       head_legal;
    logic                       head_is_clear;

    assign push_entry    = '{cmd: in_cmd, addr: in_addr};
    assign head          = trace_cmd_t'(head_raw);
    assign head_legal    = cmd_legal(head.cmd);
    assign head_is_clear = (head.cmd == CMD_CLEAR);
    assign in_ready      = !fifo_full;
    assign busy          = !fifo_empty || (state == ST_SWEEP);

    llc_sync_fifo #(
        .WIDTH ($bits(trace_cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .din   (push_entry),
        .pop   (pop),
        .head  (head_raw),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        out_valid  = 1'b0;
        out_cmd    = '0;
        out_tag    = '0;
        out_index  = '0;
        out_offset = '0;
        out_last   = 1'b0;
        pop        = 1'b0;
        case (state)
            ST_PASS: begin
                if (!fifo_empty) begin
                    if (!head_legal) begin
                        pop = 1'b1;
                    end else if (!head_is_clear) begin
                        out_valid  = 1'b1;
                        out_cmd    = head.cmd;
                        out_tag    = head.addr[ADDR_BITS-1 -: TW];
                        out_index  = head.addr[OW +: IW];
                        out_offset = head.addr[OW-1:0];
                        pop        = out_ready;
                    end
                end
            end
            ST_SWEEP: begin
                out_valid = 1'b1;
                out_cmd   = CMD_CLEAR;
                out_index = sweep_idx;
                out_last  = (sweep_idx == IW'(SETS - 1));
                // The clear entry stays at the head until its last set is issued.
                pop       = out_ready && out_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_PASS;
            sweep_idx <= '0;
            err_count <= '0;
        end else begin
            case (state)
                ST_PASS: begin
                    if (!fifo_empty && !head_legal && (err_count != 16'hFFFF))
                        err_count <= err_count + 1'b1;
                    if (!fifo_empty && head_is_clear) begin
                        state     <= ST_SWEEP;
                        sweep_idx <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= ST_PASS;
                            sweep_idx <= '0;
                        end else begin
                            sweep_idx <= sweep_idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_PASS;
            endcase
        end
    end

endmodule
